regwrite_arbiter: RTL

REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

---
 rtl/regwrite_arbiter_pkg.sv | 21 ++
 rtl/regwrite_arbiter_wb_fifo.sv | 50 +++++
 rtl/regwrite_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/regwrite_arbiter_pkg.sv
// rtl/regwrite_arbiter_pkg.sv - shared pipeline widths and write-port grant states
package regwrite_arbiter_pkg;

   localparam int REG_W    = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;
   localparam int ENTRY_W  = REG_W + DATA_W;

   typedef enum logic [3:0] {
      IDLE     = 4'b0001,
      GNT_ALU  = 4'b0010,
      GNT_FIFO = 4'b0100,
      GNT_MD   = 4'b1000
   } gnt_state_e;

   function automatic logic [ENTRY_W-1:0] pack_entry(input logic [REG_W-1:0]  r,
                                                      input logic [DATA_W-1:0] d);
      return {r, d};
   endfunction

endpackage

// File: rtl/regwrite_arbiter_wb_fifo.sv
// rtl/regwrite_arbiter_wb_fifo.sv - wb_fifo: small FIFO holding deferred mul/div writebacks
module wb_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 37
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wp_q, wp_d;
   logic [PW-1:0]    rp_q, rp_d;

   // Pointers carry one extra lap bit: equal index with differing MSB means full.
   assign empty = (wp_q == rp_q);
   assign full  = (wp_q[PW-1] != rp_q[PW-1]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign head  = mem_q[rp_q[AW-1:0]];

   always_comb begin
      wp_d = wp_q;
      rp_d = rp_q;
      if (push && !full) wp_d = wp_q + PTR_ONE;
      if (pop && !empty) rp_d = rp_q + PTR_ONE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) mem_q[wp_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/regwrite_arbiter.sv
// rtl/regwrite_arbiter.sv - register-file write-port arbiter between ALU and mul/div with RAW/WAW scoreboard
module regwrite_arbiter
   import regwrite_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_we,
   input  logic [REG_W-1:0]  alu_reg,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              md_valid,
   input  logic [REG_W-1:0]  md_reg,
   input  logic [DATA_W-1:0] md_data,
   output logic              md_ready,
   input  logic              issue_valid,
   input  logic [REG_W-1:0]  issue_reg,
   input  logic [REG_W-1:0]  read1,
   input  logic [REG_W-1:0]  read2,
   output logic              stall,
   output logic              regWrite,
   output logic [REG_W-1:0]  writeReg,
   output logic [DATA_W-1:0] writeData,
   output logic [3:0]        gnt_state
);

   logic               fifo_full, fifo_empty;
   logic [ENTRY_W-1:0] fifo_head;
   logic               fifo_push, fifo_pop;
   logic               md_acc;

   gnt_state_e         state_q, gnt_d;
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic               regWrite_q;
   logic [REG_W-1:0]   writeReg_q;
   logic [DATA_W-1:0]  writeData_q;

   logic [REG_W-1:0]   win_reg;
   logic [DATA_W-1:0]  win_data;
   logic               md_win;

   wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (pack_entry(md_reg, md_data)),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   assign md_ready = !fifo_full;
   assign md_acc   = md_valid && !fifo_full;

   // ALU cannot stall; buffered md entries drain before any new direct md write.
   always_comb begin
      gnt_d     = IDLE;
      fifo_push = 1'b0;
      fifo_pop  = 1'b0;
      win_reg   = alu_reg;
      win_data  = alu_data;
      if (alu_we) begin
         gnt_d     = GNT_ALU;
         fifo_push = md_acc;
      end else if (!fifo_empty) begin
         gnt_d     = GNT_FIFO;
         fifo_pop  = 1'b1;
         fifo_push = md_acc;
         win_reg   = fifo_head[ENTRY_W-1:DATA_W];
         win_data  = fifo_head[DATA_W-1:0];
      end else if (md_acc) begin
         gnt_d     = GNT_MD;
         win_reg   = md_reg;
         win_data  = md_data;
      end
   end

   assign md_win = (gnt_d == GNT_FIFO) || (gnt_d == GNT_MD);

   // Clear first so a same-cycle issue to the same register keeps it busy.
   always_comb begin
      busy_d = busy_q;
      if (md_win) busy_d[win_reg] = 1'b0;
      if (issue_valid && (issue_reg != '0)) busy_d[issue_reg] = 1'b1;
   end

   assign stall = (busy_q[read1] && (read1 != '0)) ||
                  (busy_q[read2] && (read2 != '0)) ||
                  (issue_valid && busy_q[issue_reg]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         busy_q      <= '0;
         regWrite_q  <= 1'b0;
         writeReg_q  <= '0;
         writeData_q <= '0;
      end else begin
         state_q    <= gnt_d;
         busy_q     <= busy_d;
         regWrite_q <= (gnt_d != IDLE) && (win_reg != '0);
         if (gnt_d != IDLE) begin
            writeReg_q  <= win_reg;
            writeData_q <= win_data;
         end
      end
   end

   assign regWrite  = regWrite_q;
   assign writeReg  = writeReg_q;
   assign writeData = writeData_q;
   assign gnt_state = state_q;

endmodule
